// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types plus the memory responder's state encoding and
// the filler word returned for reads outside the backing store.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } memresp_state_t;

    localparam word_t BADWORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_store_sp.sv
// Single-port synchronous word RAM with a registered read port; kept on its
// own so the storage array maps cleanly onto block RAM.
module mem_store_sp
    import cpu_types_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [2**AW];

    // NOTE: the array has no reset; clearing it would block RAM inference, so contents start undefined.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dcache_mem_resp.sv
// Data-memory responder for the cache's outbound port: latches one request,
// waits LAT cycles, then completes it with a one-cycle low pulse on dwait.
module dcache_mem_resp
    import cpu_types_pkg::*;
#(
    parameter int    LAT     = 2,
    parameter int    AW      = 10,
    parameter word_t BADWORD = cpu_types_pkg::BADWORD
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    output logic [15:0] xfer_count
);

    localparam logic [3:0] CNT_INIT = 4'((LAT == 0) ? 0 : LAT - 1);

    memresp_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           wr_q, wr_d;
    logic           oor_q, oor_d;
    logic [AW-1:0]  idx_q, idx_d;
    word_t          data_q, data_d;
    logic           dwait_q, dwait_d;
    word_t          dload_q, dload_d;
    logic [15:0]    xfer_q, xfer_d;
    logic           ram_we;
    word_t          ram_rdata;
    logic           unused_addr_bits;

    // Word access only: the byte offset is deliberately ignored.
    assign unused_addr_bits = ^daddr[1:0];

    // The RAM reads at idx_d so its registered output already holds the
    // addressed word by the time ACK is left, even when LAT is zero.
    mem_store_sp #(
        .AW(AW)
    ) u_store (
        .CLK  (CLK),
        .we   (ram_we),
        .idx  (idx_d),
        .wdata(data_q),
        .rdata(ram_rdata)
    );

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dwait_d = dwait_q;
        dload_d = dload_q;
        xfer_d  = xfer_q;
        ram_we  = 1'b0;

        case (state_q)
            IDLE: begin
                dwait_d = 1'b1;
                // A held request is only re-accepted once the completion pulse has ended.
                if ((dREN || dWEN) && dwait_q) begin
                    wr_d   = dWEN;
                    idx_d  = daddr[AW+1:2];
                    data_d = dstore;
                    oor_d  = |daddr[31:AW+2];
                    if (LAT == 0) begin
                        state_d = ACK;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (wr_q ? !dWEN : !dREN) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                dwait_d = 1'b0;
                xfer_d  = xfer_q + 16'd1;
                if (wr_q) begin
                    ram_we = !oor_q && nRST;
                end else begin
                    dload_d = oor_q ? BADWORD : ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            dwait_q <= 1'b1;
            dload_q <= '0;
            xfer_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            dwait_q <= dwait_d;
            dload_q <= dload_d;
            xfer_q  <= xfer_d;
        end
    end

    assign dwait      = dwait_q;
    assign dload      = dload_q;
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_dcache_mem_resp.sv
// Self-checking bench: one responder with LAT=2 and one with LAT=0, checked
// against a transaction-level memory model and a table of fixed vectors.
module tb_dcache_mem_resp;
    import cpu_types_pkg::*;

    localparam int AW = 10;

    logic        CLK = 1'b0;
    logic        nrst_a, ren_a, wen_a, wait_a;
    logic        nrst_b, ren_b, wen_b, wait_b;
    word_t       addr_a, store_a, load_a;
    word_t       addr_b, store_b, load_b;
    logic [15:0] cnt_a, cnt_b;

    always #5 CLK = ~CLK;

    dcache_mem_resp #(.LAT(2), .AW(AW)) u_a (
        .CLK(CLK), .nRST(nrst_a), .dREN(ren_a), .dWEN(wen_a), .daddr(addr_a),
        .dstore(store_a), .dwait(wait_a), .dload(load_a), .xfer_count(cnt_a)
    );

    dcache_mem_resp #(.LAT(0), .AW(AW)) u_b (
        .CLK(CLK), .nRST(nrst_b), .dREN(ren_b), .dWEN(wen_b), .daddr(addr_b),
        .dstore(store_b), .dwait(wait_b), .dload(load_b), .xfer_count(cnt_b)
    );

    int errors = 0;
    int checks = 0;

    // Which instance the transaction tasks talk to (0 = LAT 2, 1 = LAT 0).
    bit          sel_b = 1'b0;
    logic        cur_wait;
    word_t       cur_load;
    logic [15:0] cur_cnt;
    assign cur_wait = sel_b ? wait_b : wait_a;
    assign cur_load = sel_b ? load_b : load_a;
    assign cur_cnt  = sel_b ? cnt_b  : cnt_a;

    // Reference model: word store indexed by word number, plus completion counts.
    word_t       model_mem [int];
    logic [15:0] exp_cnt [2];

    typedef enum int {OP_RD = 0, OP_WR = 1, OP_BOTH = 2} op_t;

    typedef struct {
        string name;
        op_t   op;
        word_t addr;
        word_t data;
        word_t exp;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input word_t addr);
        return (addr >> (AW + 2)) == 0;
    endfunction

    function automatic int word_of(input word_t addr);
        return int'((addr >> 2) % (1 << AW));
    endfunction

    function automatic word_t model_read(input word_t addr);
        if (!in_range(addr)) return BADWORD;
        return model_mem[word_of(addr)];
    endfunction

    task automatic drive(input logic ren, input logic wen, input word_t addr, input word_t data);
        if (sel_b) begin
            ren_b = ren; wen_b = wen; addr_b = addr; store_b = data;
        end else begin
            ren_a = ren; wen_a = wen; addr_a = addr; store_a = data;
        end
    endtask

    // One complete transfer, entered and left on a falling edge.
    task automatic xfer(input string name, input op_t op, input word_t addr, input word_t data,
                        output word_t load);
        int n;
        bit seen;
        int lat;
        lat  = sel_b ? 0 : 2;
        seen = 1'b0;
        n    = 0;
        drive(op != OP_WR, op != OP_RD, addr, data);
        while (!seen && n < 40) begin
            @(posedge CLK);
            @(negedge CLK);
            // Address and data must be ignored once the request is latched.
            drive(op != OP_WR, op != OP_RD, word_t'($urandom), word_t'($urandom));
            if (!cur_wait) seen = 1'b1;
            else n++;
        end
        check({name, " latency"}, n, lat + 1);
        load = cur_load;
        exp_cnt[sel_b] = exp_cnt[sel_b] + 16'd1;
        if (op != OP_RD && in_range(addr)) model_mem[word_of(addr)] = data;
        check({name, " xfer_count"}, cur_cnt, exp_cnt[sel_b]);
        drive(1'b0, 1'b0, '0, '0);
        @(posedge CLK);
        @(negedge CLK);
        check({name, " dwait one cycle"}, cur_wait, 1'b1);
    endtask

    initial begin
        word_t load;
        word_t exp;
        word_t addr;
        op_t   op;
        bit    went_low;
        int    lows;
        int    last_low;
        int    edge_n;

        vecs = '{
            '{"wr 0x40",       OP_WR, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0},
            '{"rd 0x40",       OP_RD, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF},
            '{"wr 0x0",        OP_WR, 32'h0000_0000, 32'h0000_CAFE, 32'h0},
            '{"rd oor",        OP_RD, 32'h0000_1000, 32'h0,         32'hBAD1_BAD1},
            '{"wr oor",        OP_WR, 32'h0000_1000, 32'h0000_0001, 32'h0},
            '{"rd 0x0 kept",   OP_RD, 32'h0000_0000, 32'h0,         32'h0000_CAFE},
            '{"wr 0x20",       OP_WR, 32'h0000_0020, 32'h1111_2222, 32'h0},
            '{"rd 0x23",       OP_RD, 32'h0000_0023, 32'h0,         32'h1111_2222},
            '{"rd hi oor",     OP_RD, 32'h8000_0040, 32'h0,         32'hBAD1_BAD1},
            '{"wr last word",  OP_WR, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0},
            '{"rd last word",  OP_RD, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5},
            '{"rd 0x40 again", OP_RD, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF}
        };

        // Reset held for two cycles with a read request pending.
        nrst_a = 1'b0; nrst_b = 1'b0;
        ren_a = 1'b1; wen_a = 1'b0; addr_a = 32'h0000_1000; store_a = '0;
        ren_b = 1'b0; wen_b = 1'b0; addr_b = '0; store_b = '0;
        exp_cnt[0] = 16'd0;
        exp_cnt[1] = 16'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("reset dwait c%0d", i), wait_a, 1'b1);
            check($sformatf("reset dload c%0d", i), load_a, 32'h0);
            check($sformatf("reset count c%0d", i), cnt_a, 16'h0);
        end
        nrst_a = 1'b1; nrst_b = 1'b1;
        xfer("after reset", OP_RD, 32'h0000_1000, '0, load);
        check("after reset dload", load, BADWORD);

        // Clear the count again so the table starts from zero.
        nrst_a = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nrst_a = 1'b1;
        exp_cnt[0] = 16'd0;

        foreach (vecs[i]) begin
            xfer(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].data, load);
            if (vecs[i].op == OP_RD) check({vecs[i].name, " dload"}, load, vecs[i].exp);
        end

        // Abort: drop the read after one BUSY cycle; no completion may follow.
        drive(1'b1, 1'b0, 32'h0000_0010, '0);
        @(posedge CLK); @(negedge CLK);
        @(posedge CLK); @(negedge CLK);
        drive(1'b0, 1'b0, '0, '0);
        went_low = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); @(negedge CLK);
            if (!wait_a) went_low = 1'b1;
        end
        check("abort dwait stayed high", went_low, 1'b0);
        check("abort count unchanged", cnt_a, exp_cnt[0]);
        xfer("post-abort rd", OP_RD, 32'h0000_0040, '0, load);
        check("post-abort dload", load, 32'hDEAD_BEEF);

        // Reset while a write to 0x20 sits in BUSY: the write must be lost.
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h9999_9999);
        @(posedge CLK); @(negedge CLK);
        nrst_a = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        @(posedge CLK); @(negedge CLK);
        check("midop reset dwait", wait_a, 1'b1);
        check("midop reset dload", load_a, 32'h0);
        check("midop reset count", cnt_a, 16'h0);
        nrst_a = 1'b1;
        exp_cnt[0] = 16'd0;
        xfer("midop rd 0x20", OP_RD, 32'h0000_0020, '0, load);
        check("midop old value", load, 32'h1111_2222);

        // Randomised traffic on a small window of words plus out-of-range hits.
        for (int w = 0; w < 8; w++) begin
            xfer($sformatf("init w%0d", w), OP_WR, word_t'(w << 2), word_t'($urandom), load);
        end
        for (int t = 0; t < 40; t++) begin
            op = op_t'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0)
                addr = (word_t'($urandom_range(1, 1000)) << (AW + 2)) | word_t'($urandom_range(0, 3));
            else
                addr = (word_t'($urandom_range(0, 7)) << 2) | word_t'($urandom_range(0, 3));
            exp = model_read(addr);
            xfer($sformatf("rand %0d", t), op, addr, word_t'($urandom), load);
            if (op == OP_RD) check($sformatf("rand %0d dload", t), load, exp);
        end

        // LAT=0 instance: simultaneous read and write means write.
        sel_b = 1'b1;
        xfer("prio both", OP_BOTH, 32'h0000_0008, 32'h1234_5678, load);
        xfer("prio rd 0x8", OP_RD, 32'h0000_0008, '0, load);
        check("prio dload", load, 32'h1234_5678);

        // Counter wrap with a held read: period LAT+3 and 16'hFFFF -> 0.
        force u_b.xfer_q = 16'hFFFD;
        @(posedge CLK); @(negedge CLK);
        release u_b.xfer_q;
        exp_cnt[1] = 16'hFFFD;
        drive(1'b1, 1'b0, 32'h0000_0008, '0);
        lows = 0;
        last_low = 0;
        edge_n = 0;
        while (lows < 3 && edge_n < 30) begin
            @(posedge CLK); @(negedge CLK);
            if (!wait_b) begin
                exp_cnt[1] = exp_cnt[1] + 16'd1;
                if (lows == 0) check("held first latency", edge_n, 1);
                else check($sformatf("held period %0d", lows), edge_n - last_low, 3);
                check($sformatf("held count %0d", lows), cnt_b, exp_cnt[1]);
                check($sformatf("held dload %0d", lows), load_b, 32'h1234_5678);
                last_low = edge_n;
                lows++;
            end
            edge_n++;
        end
        check("held completions", lows, 3);
        check("count wrapped", cnt_b, 16'h0000);
        drive(1'b0, 1'b0, '0, '0);
        @(posedge CLK); @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
